// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
//    Shared definitions for the UART transmit arbiter: FSM state encoding,
//    the default packet terminator and counter widths. It also holds a helper
//    that sizes the grant index.
//    There are no ports. The package is imported by uart_tx_arbiter and rr_pick.
package uart_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_t;

   localparam logic [7:0] LOCK_CHAR_DEFAULT = 8'h0A;
   localparam int BURST_W = 8;
   localparam int IDLE_W  = 16;

   // Width of a requester index. It is never narrower than one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick
//    Combinational round-robin picker. It finds the first set bit of req,
//    starting at index ptr and wrapping back to index 0.
// Ports
//    req    in   N   request vector
//    ptr    in   W   index where the search starts (must be < N)
//    gnt    out  N   one-hot copy of the chosen request
//    idx    out  W   index of the chosen request
//    found  out  1   at least one request was present
module rr_pick
   import uart_arb_pkg::*;
#(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic [W-1:0] idx,
   output logic         found
);

   // Walk the requesters in rotation order from ptr and keep only the first hit.
   always_comb begin
      int cand;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int k = 0; k < N; k++) begin
         cand = int'(ptr) + k;
         if (cand >= N) begin
            cand = cand - N;
         end
         if (!found && req[cand]) begin
            found     = 1'b1;
            idx       = W'(cand);
            gnt[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//    Shares one UART transmitter between NUM_REQ byte-stream requesters.
//    Grants rotate round-robin. While a requester owns the transmitter, its
//    valid/data/ready signals pass straight through to the UART with no added
//    latency.
//
//    Build option UART_ARB_PKT_LOCK_EN:
//       defined   - The owner keeps the grant until one of these happens: it
//                   sends LOCK_CHAR, it reaches BURST_MAX bytes, or its valid
//                   stays low for IDLE_TIMEOUT cycles.
//       undefined - Arbitration happens per byte. Every transfer releases the
//                   grant, and so does any cycle where the owner's valid is low.
// Ports
//    clk        in   1            system clock
//    rst        in   1            synchronous, active-high reset
//    req_valid  in   NUM_REQ      requester i offers req_data[8*i+:8]
//    req_data   in   8*NUM_REQ    packed requester bytes
//    req_ready  out  NUM_REQ      requester i's byte is taken when valid&ready
//    tx_data    out  8            byte to the UART (0 when tx_valid is low)
//    tx_valid   out  1            tx_data is valid
//    tx_ready   in   1            UART can accept a byte
//    grant_id   out  id_width     current owner, 0 when idle
//    busy       out  1            a requester owns the transmitter
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int         NUM_REQ      = 2,
   parameter int         BURST_MAX    = 16,
   parameter int         IDLE_TIMEOUT = 64,
   parameter logic [7:0] LOCK_CHAR    = LOCK_CHAR_DEFAULT
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [8*NUM_REQ-1:0]            req_data,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic [7:0]                      tx_data,
   output logic                            tx_valid,
   input  logic                            tx_ready,
   output logic [id_width(NUM_REQ)-1:0]    grant_id,
   output logic                            busy
);

   localparam int GID_W = id_width(NUM_REQ);

`ifdef UART_ARB_PKT_LOCK_EN
   localparam int EFF_BURST   = BURST_MAX;
   localparam int EFF_IDLE    = IDLE_TIMEOUT;
   localparam bit LOCK_CHK_EN = 1'b1;
`else
   localparam int EFF_BURST   = 1;
   localparam int EFF_IDLE    = 1;
   localparam bit LOCK_CHK_EN = 1'b0;
`endif

   arb_state_t           state;
   logic [GID_W-1:0]     owner;
   logic [NUM_REQ-1:0]   owner_oh;
   logic [GID_W-1:0]     rr_ptr;
   logic [BURST_W-1:0]   burst_cnt;
   logic [IDLE_W-1:0]    idle_cnt;

   logic [NUM_REQ-1:0]   pick_gnt;
   logic [GID_W-1:0]     pick_idx;
   logic                 pick_found;

   logic                 owner_valid;
   logic [7:0]           owner_byte;
   logic                 hs;
   logic [BURST_W:0]     burst_next;
   logic [IDLE_W:0]      idle_next;
   logic                 release_now;
   logic [GID_W-1:0]     next_ptr;

   rr_pick #(
      .N (NUM_REQ),
      .W (GID_W)
   ) u_pick (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .gnt   (pick_gnt),
      .idx   (pick_idx),
      .found (pick_found)
   );

   // Owner pass-through. Nothing reaches the UART in IDLE. The data bus is
   // forced to 0 whenever the byte is not valid.
   always_comb begin
      owner_valid = req_valid[owner];
      owner_byte  = req_data[{owner, 3'b000} +: 8];
      tx_valid    = 1'b0;
      tx_data     = 8'h00;
      req_ready   = '0;
      if (state == ST_GRANT) begin
         tx_valid  = owner_valid;
         tx_data   = owner_valid ? owner_byte : 8'h00;
         req_ready = owner_oh & {NUM_REQ{tx_ready}};
      end
   end

   // Release decision for the current grant. A byte transferred in the release
   // cycle is still delivered, because the handshake is combinational.
   always_comb begin
      hs          = tx_valid & tx_ready;
      burst_next  = {1'b0, burst_cnt} + {{BURST_W{1'b0}}, 1'b1};
      idle_next   = {1'b0, idle_cnt} + {{IDLE_W{1'b0}}, 1'b1};
      release_now = 1'b0;
      if (state == ST_GRANT) begin
         if (hs && LOCK_CHK_EN && (tx_data == LOCK_CHAR)) begin
            release_now = 1'b1;
         end
         if (hs && (burst_next == (BURST_W+1)'(EFF_BURST))) begin
            release_now = 1'b1;
         end
         if (!owner_valid && (idle_next == (IDLE_W+1)'(EFF_IDLE))) begin
            release_now = 1'b1;
         end
      end
      next_ptr = (owner == GID_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
   end

   // Arbitration FSM. The counters track the current grant only and restart
   // on every new grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         owner     <= '0;
         owner_oh  <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
         idle_cnt  <= '0;
         grant_id  <= '0;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_found) begin
                  state     <= ST_GRANT;
                  owner     <= pick_idx;
                  owner_oh  <= pick_gnt;
                  grant_id  <= pick_idx;
                  busy      <= 1'b1;
                  burst_cnt <= '0;
                  idle_cnt  <= '0;
               end
            end
            ST_GRANT: begin
               if (release_now) begin
                  state     <= ST_IDLE;
                  rr_ptr    <= next_ptr;
                  owner_oh  <= '0;
                  burst_cnt <= '0;
                  idle_cnt  <= '0;
                  grant_id  <= '0;
                  busy      <= 1'b0;
               end else begin
                  if (hs && (burst_cnt != BURST_W'(EFF_BURST))) begin
                     burst_cnt <= burst_cnt + 1'b1;
                  end
                  idle_cnt <= owner_valid ? '0 : idle_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//    Bench for uart_tx_arbiter. It uses three requesters so that pointer
//    wrap-around is exercised with a non-power-of-two count.
//    A grant-level model predicts the outputs every cycle. A per-requester
//    scoreboard checks byte order and catches lost or duplicated bytes.
//    Directed lines have literal expected output sequences.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ      = 3;
   localparam int BURST_MAX    = 16;
   localparam int IDLE_TIMEOUT = 64;
   localparam int GID_W        = 2;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [NUM_REQ-1:0]     req_valid = '0;
   logic [8*NUM_REQ-1:0]   req_data = '0;
   logic [NUM_REQ-1:0]     req_ready;
   logic [7:0]             tx_data;
   logic                   tx_valid;
   logic                   tx_ready = 1'b1;
   logic [GID_W-1:0]       grant_id;
   logic                   busy;

   int total = 0;
   int bad   = 0;
   int cycle = 0;

   logic [7:0] src_q[NUM_REQ][$];
   logic [7:0] sent_hist[NUM_REQ][$];
   int         dut_cnt[NUM_REQ];
   logic [7:0] out_bytes[$];
   int         out_src[$];
   int         valid_pct = 100;
   bit         last_hs = 1'b0;

   bit m_busy  = 1'b0;
   int m_owner = 0;
   int m_ptr   = 0;
   int m_bytes = 0;
   int m_low   = 0;

   uart_tx_arbiter #(
      .NUM_REQ      (NUM_REQ),
      .BURST_MAX    (BURST_MAX),
      .IDLE_TIMEOUT (IDLE_TIMEOUT),
      .LOCK_CHAR    (8'h0A)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   task automatic applyStimulus(input int r, input string s);
      for (int k = 0; k < s.len(); k++) begin
         src_q[r].push_back(s[k]);
         sent_hist[r].push_back(s[k]);
      end
   endtask

   task automatic pushByte(input int r, input logic [7:0] b);
      src_q[r].push_back(b);
      sent_hist[r].push_back(b);
   endtask

   task automatic doReset();
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      out_bytes.delete();
      out_src.delete();
   endtask

   task automatic waitDrain(input int max_cycles);
      int n;
      int left;
      n = 0;
      left = 0;
      for (int r = 0; r < NUM_REQ; r++) left += src_q[r].size();
      while (left != 0 && n < max_cycles) begin
         @(negedge clk);
         n++;
         left = 0;
         for (int r = 0; r < NUM_REQ; r++) left += src_q[r].size();
      end
      checkOutput("drain_remaining", left, 0);
      repeat (IDLE_TIMEOUT + 16) @(negedge clk);
   endtask

   task automatic waitHandshake(input int gid, input int max_cycles);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < max_cycles) begin
         @(negedge clk);
         n++;
         seen = tx_valid && tx_ready && (int'(grant_id) == gid);
      end
      checkOutput("hs_seen", 32'(seen), 1);
   endtask

   task automatic checkSequence(input string name, input logic [7:0] exp_b[$]);
      checkOutput({name, "_len"}, out_bytes.size(), exp_b.size());
      for (int k = 0; k < exp_b.size() && k < out_bytes.size(); k++) begin
         checkOutput($sformatf("%s_byte%0d", name, k), 32'(out_bytes[k]), 32'(exp_b[k]));
      end
   endtask

   // Requester and UART stimulus. The head byte stays on the bus until it is
   // taken. Valid may drop at random, and the data is garbage while valid is low.
   // The UART drops ready for 10 cycles after each accepted byte.
   initial begin
      int uart_cnt;
      uart_cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (last_hs) uart_cnt = 10;
         else if (uart_cnt > 0) uart_cnt--;
         tx_ready = (uart_cnt == 0);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (src_q[i].size() > 0 && $urandom_range(99) < valid_pct) begin
               req_valid[i] = 1'b1;
               req_data[8*i +: 8] = src_q[i][0];
            end else begin
               req_valid[i] = 1'b0;
               req_data[8*i +: 8] = 8'($urandom);
            end
         end
      end
   end

   // Every cycle: compare the DUT against the grant-level model, score the
   // bytes it delivers, then advance the model to the next cycle.
   initial begin
      logic [NUM_REQ-1:0] exp_rr;
      logic [7:0]         exp_td;
      bit                 exp_tv;
      bit                 hs;
      bit                 rel;
      bit                 found;
      int                 idx;
      int                 gid;
      forever begin
         @(negedge clk);
         cycle++;
         exp_tv = m_busy && req_valid[m_owner];
         exp_td = exp_tv ? req_data[8*m_owner +: 8] : 8'h00;
         exp_rr = '0;
         if (m_busy) exp_rr[m_owner] = tx_ready;
         checkOutput("busy", 32'(busy), 32'(m_busy));
         checkOutput("grant_id", 32'(grant_id), m_busy ? m_owner : 0);
         checkOutput("tx_valid", 32'(tx_valid), 32'(exp_tv));
         checkOutput("tx_data", 32'(tx_data), 32'(exp_td));
         checkOutput("req_ready", 32'(req_ready), 32'(exp_rr));

         if (tx_valid && tx_ready) begin
            gid = int'(grant_id);
            out_bytes.push_back(tx_data);
            out_src.push_back(gid);
            if (gid >= NUM_REQ) begin
               checkOutput("sb_gid", gid, NUM_REQ - 1);
            end else if (dut_cnt[gid] >= sent_hist[gid].size()) begin
               checkOutput("sb_overrun", dut_cnt[gid], sent_hist[gid].size() - 1);
            end else begin
               checkOutput("sb_order", 32'(tx_data), 32'(sent_hist[gid][dut_cnt[gid]]));
               dut_cnt[gid]++;
            end
         end

         hs = exp_tv && tx_ready;
         last_hs = hs;
         if (hs) src_q[m_owner].pop_front();

         if (rst) begin
            m_busy = 1'b0;
            m_ptr  = 0;
         end else if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < NUM_REQ; k++) begin
               idx = (m_ptr + k) % NUM_REQ;
               if (!found && req_valid[idx]) begin
                  found   = 1'b1;
                  m_owner = idx;
               end
            end
            if (found) begin
               m_busy  = 1'b1;
               m_bytes = 0;
               m_low   = 0;
            end
         end else begin
            rel = 1'b0;
`ifdef UART_ARB_PKT_LOCK_EN
            if (hs) begin
               m_bytes++;
               if (exp_td == 8'h0A || m_bytes == BURST_MAX) rel = 1'b1;
            end
            if (!req_valid[m_owner]) begin
               m_low++;
               if (m_low == IDLE_TIMEOUT) rel = 1'b1;
            end else begin
               m_low = 0;
            end
`else
            rel = hs || !req_valid[m_owner];
`endif
            if (rel) begin
               m_busy = 1'b0;
               m_ptr  = (m_owner + 1) % NUM_REQ;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: run did not finish, total=%0d", total);
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] exp_b[$];
      int n;
      int nb;

      $display("[TB] reset");
      repeat (10) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_tx_valid", 32'(tx_valid), 0);
      checkOutput("rst_tx_data", 32'(tx_data), 0);
      checkOutput("rst_req_ready", 32'(req_ready), 0);
      checkOutput("rst_grant_id", 32'(grant_id), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      $display("[TB] single line ab");
      applyStimulus(0, "ab\n");
      n = 0;
      while (!(tx_valid && tx_ready && tx_data == 8'h0A) && n < 500) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      checkOutput("ab_busy_fall", 32'(busy), 0);
      waitDrain(2000);
      exp_b = '{8'h61, 8'h62, 8'h0A};
      checkSequence("ab", exp_b);
      for (int k = 0; k < out_src.size(); k++) checkOutput("ab_src", out_src[k], 0);

      $display("[TB] two lines same cycle");
      doReset();
      applyStimulus(0, "hi\n");
      applyStimulus(1, "ok\n");
      waitDrain(2000);
`ifdef UART_ARB_PKT_LOCK_EN
      exp_b = '{8'h68, 8'h69, 8'h0A, 8'h6F, 8'h6B, 8'h0A};
`else
      exp_b = '{8'h68, 8'h6F, 8'h69, 8'h6B, 8'h0A, 8'h0A};
`endif
      checkSequence("hiok", exp_b);

      $display("[TB] burst cap");
      doReset();
      for (int i = 0; i < 20; i++) pushByte(0, 8'(8'h30 + i));
      applyStimulus(1, "ok\n");
      waitDrain(4000);
      exp_b.delete();
`ifdef UART_ARB_PKT_LOCK_EN
      for (int i = 0; i < 16; i++) exp_b.push_back(8'(8'h30 + i));
      exp_b.push_back(8'h6F);
      exp_b.push_back(8'h6B);
      exp_b.push_back(8'h0A);
      for (int i = 16; i < 20; i++) exp_b.push_back(8'(8'h30 + i));
`else
      exp_b = '{8'h30, 8'h6F, 8'h31, 8'h6B, 8'h32, 8'h0A};
      for (int i = 3; i < 20; i++) exp_b.push_back(8'(8'h30 + i));
`endif
      checkSequence("burst", exp_b);

      $display("[TB] owner goes idle");
      doReset();
      applyStimulus(0, "A");
      applyStimulus(1, "ok\n");
      waitHandshake(0, 500);
      n = 0;
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
`ifdef UART_ARB_PKT_LOCK_EN
      checkOutput("idle_release_cycles", n, IDLE_TIMEOUT + 1);
`else
      checkOutput("idle_release_cycles", n, 1);
`endif
      @(negedge clk);
      checkOutput("idle_next_busy", 32'(busy), 1);
      checkOutput("idle_next_gid", 32'(grant_id), 1);
      waitDrain(2000);

      $display("[TB] reset mid packet");
      doReset();
      applyStimulus(1, "xyz\n");
      waitHandshake(1, 500);
      applyStimulus(0, "q\n");
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_tx_valid", 32'(tx_valid), 0);
      checkOutput("midrst_busy", 32'(busy), 0);
      checkOutput("midrst_gid", 32'(grant_id), 0);
      @(negedge clk);
      checkOutput("midrst_regrant_busy", 32'(busy), 1);
      checkOutput("midrst_regrant_gid", 32'(grant_id), 0);
      waitDrain(2000);

      $display("[TB] random traffic");
      valid_pct = 75;
      for (int round = 0; round < 3; round++) begin
         for (int r = 0; r < NUM_REQ; r++) begin
            nb = $urandom_range(25, 5);
            for (int k = 0; k < nb; k++) begin
               if ($urandom_range(9) == 0) pushByte(r, 8'h0A);
               else pushByte(r, 8'($urandom_range(8'h7E, 8'h20)));
            end
         end
         waitDrain(20000);
      end

      for (int r = 0; r < NUM_REQ; r++) begin
         checkOutput($sformatf("delivered_r%0d", r), dut_cnt[r], sent_hist[r].size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
